// File: rtl/riskv_pkg.sv
// Shared types for the RISKV core writeback path.
//   result_src_t : writeback result selector (ALU / LOAD / PC4; 2'b11 is reserved and behaves as ALU)
//   mem_type_t   : load access size (BYTE / HALF / WORD; 2'b11 is reserved and behaves as WORD)
//   wb_state_t   : writeback FSM states
package riskv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_type_t;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_RD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load extraction/extension.
// Picks the addressed byte or halfword out of a naturally aligned 32-bit memory
// word and sign- or zero-extends it to 32 bits.
// Ports:
//   raw_i  [31:0] aligned data word from memory
//   off_i  [1:0]  byte offset within the word (off_i[0] ignored for halfwords)
//   type_i [1:0]  access size (mem_type_t encoding; 2'b11 treated as word)
//   sign_i        1 = sign-extend, 0 = zero-extend
//   data_o [31:0] extended load value
module load_extend
  import riskv_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (type_i)
      MEM_BYTE: data_o = ext_byte(byte_sel, sign_i);
      MEM_HALF: data_o = ext_half(half_sel, sign_i);
      default:  data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM->WB pipeline register and writeback logic of the RISKV 5-stage core.
// Captures the M-stage bundle, waits for variable-latency load data, extends
// byte/half/word loads and selects the value written to the register file.
// While a load is outstanding the stage requests a stall of M and upstream.
// Optional feature: define WB_INSTRET_EN to add a 64-bit retired-instruction
// counter on instret_o.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ValidM_i        M-stage slot holds a real instruction
//   ALUResultM_i    ALU result / load address ([1:0] = byte offset)
//   RD_i            raw aligned load data, qualified by mem_rvalid_i
//   PCPlus4M_i      link value for JAL/JALR
//   RdM_i           destination register
//   RegWriteM_i     instruction writes rd
//   ResultSrcM_i    00 ALU, 01 load, 10 PC+4, 11 as ALU
//   MemType_i       00 byte, 01 half, 10 word, 11 as word
//   MemSign_i       load sign-extension select
//   flush_i         squash M slot and any pending load
//   ResultW_o       writeback data (holds when no write)
//   RdW_o           writeback register index
//   RegWriteW_o     register-file write pulse
//   StallMW_o       stall request, high only while waiting for load data
//   load_err_o      pulse when a load is abandoned on timeout
//   instret_o       retired-instruction count (WB_INSTRET_EN only)
module writeback_stage
  import riskv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] RD_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4M_i,
  input  logic [4:0]            RdM_i,
  input  logic                  RegWriteM_i,
  input  logic [1:0]            ResultSrcM_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [4:0]            RdW_o,
  output logic                  RegWriteW_o,
  output logic                  StallMW_o,
  output logic                  load_err_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  // Wide enough to hold TIMEOUT_CYCLES-1 for any TIMEOUT_CYCLES >= 1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load context latched when data does not return in the accept cycle.
  logic [1:0]       off_q, off_d;
  logic [1:0]       type_q, type_d;
  logic             sign_q, sign_d;
  logic [4:0]       rdp_q, rdp_d;
  logic             regwp_q, regwp_d;

  logic [31:0]      result_q, result_d;
  logic [4:0]       rdw_q, rdw_d;
  logic             we_q, we_d;
  logic             err_q, err_d;

  logic             is_load;
  logic [1:0]       ext_off;
  logic [1:0]       ext_type;
  logic             ext_sign;
  logic [31:0]      ext_data;

  assign is_load = (ResultSrcM_i == RES_LOAD);

  // The extender sees live M-stage controls in IDLE and the latched ones while waiting.
  assign ext_off  = (state_q == WB_IDLE) ? ALUResultM_i[1:0] : off_q;
  assign ext_type = (state_q == WB_IDLE) ? MemType_i         : type_q;
  assign ext_sign = (state_q == WB_IDLE) ? MemSign_i         : sign_q;

  load_extend u_load_extend (
    .raw_i  (RD_i),
    .off_i  (ext_off),
    .type_i (ext_type),
    .sign_i (ext_sign),
    .data_o (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    type_d   = type_q;
    sign_d   = sign_q;
    rdp_d    = rdp_q;
    regwp_d  = regwp_q;
    result_d = result_q;
    rdw_d    = rdw_q;
    we_d     = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (ValidM_i && !flush_i) begin
          if (is_load && !mem_rvalid_i) begin
            off_d   = ALUResultM_i[1:0];
            type_d  = MemType_i;
            sign_d  = MemSign_i;
            rdp_d   = RdM_i;
            regwp_d = RegWriteM_i;
            cnt_d   = '0;
            state_d = WB_WAIT_RD;
          end else begin
            we_d = RegWriteM_i && (RdM_i != 5'd0);
            if (we_d) begin
              rdw_d = RdM_i;
              if (is_load)
                result_d = ext_data;
              else if (ResultSrcM_i == RES_PC4)
                result_d = PCPlus4M_i;
              else
                result_d = ALUResultM_i;
            end
          end
        end
      end

      WB_WAIT_RD: begin
        // Flush beats data; data beats timeout.
        if (flush_i) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else if (mem_rvalid_i) begin
          we_d = regwp_q && (rdp_q != 5'd0);
          if (we_d) begin
            result_d = ext_data;
            rdw_d    = rdp_q;
          end
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = WB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_IDLE;
      cnt_q    <= '0;
      regwp_q  <= 1'b0;
      result_q <= '0;
      rdw_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      regwp_q  <= regwp_d;
      result_q <= result_d;
      rdw_q    <= rdw_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  // Pure load context: only meaningful while WAIT_RD, so no reset needed.
  always_ff @(posedge clk) begin
    off_q  <= off_d;
    type_q <= type_d;
    sign_q <= sign_d;
    rdp_q  <= rdp_d;
  end

  assign ResultW_o   = result_q;
  assign RdW_o       = rdw_q;
  assign RegWriteW_o = we_q;
  assign StallMW_o   = (state_q == WB_WAIT_RD);
  assign load_err_o  = err_q;

`ifdef WB_INSTRET_EN
  // An instruction retires when it leaves toward W with a result (or no result
  // needed); abandoned and flushed loads never retire.
  logic        retire;
  logic [63:0] instret_q;

  assign retire = ((state_q == WB_IDLE) && ValidM_i && !flush_i && (!is_load || mem_rvalid_i))
               || ((state_q == WB_WAIT_RD) && !flush_i && mem_rvalid_i);

  always_ff @(posedge clk) begin
    if (rst)
      instret_q <= '0;
    else if (retire)
      instret_q <= instret_q + 64'd1;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM_i;
  logic [31:0] ALUResultM_i;
  logic [31:0] RD_i;
  logic        mem_rvalid_i;
  logic [31:0] PCPlus4M_i;
  logic [4:0]  RdM_i;
  logic        RegWriteM_i;
  logic [1:0]  ResultSrcM_i;
  logic [1:0]  MemType_i;
  logic        MemSign_i;
  logic        flush_i;
  logic [31:0] ResultW_o;
  logic [4:0]  RdW_o;
  logic        RegWriteW_o;
  logic        StallMW_o;
  logic        load_err_o;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
`endif

  writeback_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ValidM_i     (ValidM_i),
    .ALUResultM_i (ALUResultM_i),
    .RD_i         (RD_i),
    .mem_rvalid_i (mem_rvalid_i),
    .PCPlus4M_i   (PCPlus4M_i),
    .RdM_i        (RdM_i),
    .RegWriteM_i  (RegWriteM_i),
    .ResultSrcM_i (ResultSrcM_i),
    .MemType_i    (MemType_i),
    .MemSign_i    (MemSign_i),
    .flush_i      (flush_i),
    .ResultW_o    (ResultW_o),
    .RdW_o        (RdW_o),
    .RegWriteW_o  (RegWriteW_o),
    .StallMW_o    (StallMW_o),
    .load_err_o   (load_err_o)
`ifdef WB_INSTRET_EN
    ,
    .instret_o    (instret_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;
  longint      exp_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: load value computed arithmetically from the word, offset, size and sign.
  function automatic logic [31:0] model_result(input logic [1:0] src, input logic [1:0] mtype,
                                               input logic sign, input logic [31:0] alu,
                                               input logic [31:0] word, input logic [31:0] pc4);
    longint w, v;
    int off;
    w = longint'(word);
    off = int'(alu % 4);
    if (src == 2'd1) begin
      if (mtype == 2'd0) begin
        v = (w / (longint'(1) << (8 * off))) % 256;
        if (sign && v >= 128) v = v - 256;
      end else if (mtype == 2'd1) begin
        v = (w / (longint'(1) << (16 * (off / 2)))) % 65536;
        if (sign && v >= 32768) v = v - 65536;
      end else begin
        v = w;
      end
      return v[31:0];
    end
    if (src == 2'd2) return pc4;
    return alu;
  endfunction

  task automatic idle_inputs();
    ValidM_i = 0; mem_rvalid_i = 0; flush_i = 0; RegWriteM_i = 0;
    ResultSrcM_i = 0; MemType_i = 0; MemSign_i = 0; RdM_i = 0;
    ALUResultM_i = 0; RD_i = 0; PCPlus4M_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    prev_res = 0; prev_rd = 0; exp_instret = 0;
  endtask

  // One instruction through W; lat = cycles after accept until rvalid (0 = same cycle).
  task automatic do_op(input string name, input logic [1:0] src, input logic [1:0] mtype,
                       input logic sign, input logic [31:0] alu, input logic [31:0] word,
                       input logic [31:0] pc4, input logic [4:0] rd, input logic regw,
                       input int lat, input logic [31:0] exp_res, input logic exp_we,
                       input logic exp_err);
    int nst;
    ValidM_i = 1; ResultSrcM_i = src; MemType_i = mtype; MemSign_i = sign;
    ALUResultM_i = alu; PCPlus4M_i = pc4; RdM_i = rd; RegWriteM_i = regw; flush_i = 0;
    if (src == 2'd1 && lat > 0) begin
      mem_rvalid_i = 0; RD_i = $urandom;
    end else begin
      mem_rvalid_i = (src == 2'd1); RD_i = word;
    end
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    if (src == 2'd1 && lat > 0) begin
      nst = (lat > TO) ? TO : lat;
      for (int c = 1; c <= nst; c++) begin
        chk({name, " stall"}, StallMW_o, 1'b1);
        chk({name, " nowrite_wait"}, RegWriteW_o, 1'b0);
        if (c == lat) begin mem_rvalid_i = 1; RD_i = word; end
        @(posedge clk); #1;
        mem_rvalid_i = 0;
      end
    end
    ValidM_i = 0;
    chk({name, " stall_low"}, StallMW_o, 1'b0);
    chk({name, " we"}, RegWriteW_o, exp_we);
    chk({name, " err"}, load_err_o, exp_err);
    chk({name, " result"}, ResultW_o, exp_we ? exp_res : prev_res);
    chk({name, " rdw"}, RdW_o, exp_we ? rd : prev_rd);
    if (exp_we) begin prev_res = exp_res; prev_rd = rd; end
    if (!exp_err) exp_instret++;
    @(posedge clk); #1;
    chk({name, " we_pulse"}, RegWriteW_o, 1'b0);
    chk({name, " err_pulse"}, load_err_o, 1'b0);
    chk({name, " hold"}, ResultW_o, prev_res);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  src, mtype;
    logic        sign;
    logic [31:0] alu, word, pc4;
    logic [4:0]  rd;
    logic        regw;
    int          lat;
    logic [31:0] exp_res;
    logic        exp_we, exp_err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"alu",      2'd0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 32'h0,   5'd5,  1'b1, 0, 32'h0000_1234, 1'b1, 1'b0};
    tbl[1]  = '{"lb_s",     2'd1, 2'd0, 1'b1, 32'h0000_1003, 32'h80FF_0000, 32'h0, 5'd6, 1'b1, 0, 32'hFFFF_FF80, 1'b1, 1'b0};
    tbl[2]  = '{"lbu",      2'd1, 2'd0, 1'b0, 32'h0000_1003, 32'h80FF_0000, 32'h0, 5'd7, 1'b1, 0, 32'h0000_0080, 1'b1, 1'b0};
    tbl[3]  = '{"lh_late",  2'd1, 2'd1, 1'b1, 32'h0000_2002, 32'hBEEF_0000, 32'h0, 5'd8, 1'b1, 3, 32'hFFFF_BEEF, 1'b1, 1'b0};
    tbl[4]  = '{"timeout",  2'd1, 2'd2, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 9, 32'h0,         1'b0, 1'b1};
    tbl[5]  = '{"jal_x0",   2'd2, 2'd0, 1'b0, 32'h0000_5555, 32'h0, 32'h0000_0104, 5'd0, 1'b1, 0, 32'h0,       1'b0, 1'b0};
    tbl[6]  = '{"jal_x1",   2'd2, 2'd0, 1'b0, 32'h0000_5555, 32'h0, 32'h0000_0104, 5'd1, 1'b1, 0, 32'h0000_0104, 1'b1, 1'b0};
    tbl[7]  = '{"lhu_off3", 2'd1, 2'd1, 1'b0, 32'h0000_0003, 32'hBEEF_1234, 32'h0, 5'd10, 1'b1, 0, 32'h0000_BEEF, 1'b1, 1'b0};
    tbl[8]  = '{"lb_pos",   2'd1, 2'd0, 1'b1, 32'h0000_0001, 32'h0000_7F00, 32'h0, 5'd11, 1'b1, 0, 32'h0000_007F, 1'b1, 1'b0};
    tbl[9]  = '{"src_rsv",  2'd3, 2'd0, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0000_0200, 5'd12, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b0};
    tbl[10] = '{"type_rsv", 2'd1, 2'd3, 1'b1, 32'h0000_0001, 32'h8765_4321, 32'h0, 5'd13, 1'b1, TO, 32'h8765_4321, 1'b1, 1'b0};
    tbl[11] = '{"no_regw",  2'd0, 2'd0, 1'b0, 32'h1111_2222, 32'h0, 32'h0,     5'd14, 1'b0, 0, 32'h0,          1'b0, 1'b0};

    do_reset();
    chk("rst ResultW", ResultW_o, 32'h0);
    chk("rst RdW", RdW_o, 5'd0);
    chk("rst RegWriteW", RegWriteW_o, 1'b0);
    chk("rst StallMW", StallMW_o, 1'b0);
    chk("rst load_err", load_err_o, 1'b0);

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].name, tbl[i].src, tbl[i].mtype, tbl[i].sign, tbl[i].alu, tbl[i].word,
            tbl[i].pc4, tbl[i].rd, tbl[i].regw, tbl[i].lat, tbl[i].exp_res, tbl[i].exp_we,
            tbl[i].exp_err);

    // Flush while waiting, then late data must not be written.
    ValidM_i = 1; ResultSrcM_i = 2'd1; MemType_i = 2'd2; MemSign_i = 0;
    ALUResultM_i = 32'h40; RdM_i = 5'd15; RegWriteM_i = 1; mem_rvalid_i = 0;
    @(posedge clk); #1;
    chk("flush stall_before", StallMW_o, 1'b1);
    flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0; ValidM_i = 0;
    chk("flush stall_drop", StallMW_o, 1'b0);
    chk("flush err", load_err_o, 1'b0);
    mem_rvalid_i = 1; RD_i = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    chk("flush late_rvalid we", RegWriteW_o, 1'b0);
    chk("flush hold", ResultW_o, prev_res);
    repeat (TO + 1) @(posedge clk);
    #1 chk("flush no_err_later", load_err_o, 1'b0);

    // Flush in IDLE and a bubble: no write.
    ValidM_i = 1; flush_i = 1; ResultSrcM_i = 2'd0; ALUResultM_i = 32'h77; RdM_i = 5'd3; RegWriteM_i = 1;
    @(posedge clk); #1;
    flush_i = 0; ValidM_i = 0;
    chk("idle_flush we", RegWriteW_o, 1'b0);
    @(posedge clk); #1;
    chk("bubble we", RegWriteW_o, 1'b0);
    chk("bubble hold", ResultW_o, prev_res);

`ifdef WB_INSTRET_EN
    chk("instret", instret_o, exp_instret);
`endif

    // Reset while waiting for a load.
    ValidM_i = 1; ResultSrcM_i = 2'd1; MemType_i = 2'd2; ALUResultM_i = 32'h80; RdM_i = 5'd4; RegWriteM_i = 1;
    @(posedge clk); #1;
    ValidM_i = 0;
    chk("rstwait stall", StallMW_o, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rstwait stall_low", StallMW_o, 1'b0);
    chk("rstwait we", RegWriteW_o, 1'b0);
    chk("rstwait err", load_err_o, 1'b0);
    chk("rstwait result", ResultW_o, 32'h0);
    prev_res = 0; prev_rd = 0; exp_instret = 0;
    mem_rvalid_i = 1; RD_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    chk("rstwait late we", RegWriteW_o, 1'b0);

    // Randomized instructions against the arithmetic reference.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  src, mtype;
      logic        sign, regw, ew, ee;
      logic [31:0] alu, word, pc4;
      logic [4:0]  rd;
      int          lat;
      src = 2'($urandom_range(0, 3)); mtype = 2'($urandom_range(0, 3));
      sign = 1'($urandom); alu = $urandom; word = $urandom; pc4 = $urandom;
      rd = 5'($urandom_range(0, 31)); regw = ($urandom_range(0, 7) != 0);
      lat = (src == 2'd1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO + 2)) : 0;
      ee = (src == 2'd1) && (lat > TO);
      ew = regw && (rd != 0) && !ee;
      do_op("rand", src, mtype, sign, alu, word, pc4, rd, regw, lat,
            model_result(src, mtype, sign, alu, word, pc4), ew, ee);
    end

`ifdef WB_INSTRET_EN
    chk("instret final", instret_o, exp_instret);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
